// File: rtl/mac_combiner_n_if.sv
// -----------------------------------------------------------------------------
// mac_combiner_n_if
//   Bundles the input beat (mode/acc_en/load/init_val/partials with
//   in_valid/in_ready) and the result side (out/ovf with out_valid/out_ready)
//   of the MAC combiner.
//   master : upstream multiplier array + downstream mux (drives the beat and
//            out_ready, observes in_ready and results)
//   slave  : the combiner itself
// -----------------------------------------------------------------------------
interface mac_combiner_n_if #(
  parameter int LANES     = 4,
  parameter int INT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
);
  logic [2:0]                 mode;
  logic                       acc_en;
  logic                       load;
  logic [LANES*ACC_WIDTH-1:0] init_val;
  logic [LANES*INT_WIDTH-1:0] partials;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*ACC_WIDTH-1:0] out;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES-1:0]           ovf;

  modport master (
    output mode, acc_en, load, init_val, partials, in_valid, out_ready,
    input  in_ready, out, out_valid, ovf
  );

  modport slave (
    input  mode, acc_en, load, init_val, partials, in_valid, out_ready,
    output in_ready, out, out_valid, ovf
  );
endinterface

// File: rtl/mac_combiner_n.sv
// -----------------------------------------------------------------------------
// mac_combiner_n
//   Two-stage MAC combiner. Stage 1 merges LANES unsigned partial products into
//   aligned groups of 2^mode lanes (lane j of a group shifted by j*MIN_WIDTH).
//   Stage 2 either passes the combined value through or adds it into a
//   per-lane accumulator whose carries ripple across the lanes of a group,
//   with a sticky overflow flag on the top lane of each group.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - mac_combiner_n_if.slave (beat in, result out, valid/ready both)
// -----------------------------------------------------------------------------
module mac_combiner_n #(
  parameter int LANES     = 4,
  parameter int MIN_WIDTH = 8,
  parameter int INT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  mac_combiner_n_if.slave  bus
);
  localparam int LOG2_LANES = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int TOTAL      = LANES * ACC_WIDTH;

  typedef logic [TOTAL-1:0] vec_t;
  typedef logic [TOTAL:0]   wide_t;   // one spare bit for the group carry

  // Low g*ACC_WIDTH bits set: the span of one group of g lanes.
  function automatic vec_t group_mask(input int g);
    if (g >= LANES) return '1;
    return (vec_t'(1) << (g * ACC_WIDTH)) - vec_t'(1);
  endfunction

  // Stage 1 registers (beat attributes travel with the combined value)
  logic       s1_valid_q,  s1_valid_d;
  logic [2:0] s1_mode_q,   s1_mode_d;    // already clamped to LOG2_LANES
  logic       s1_acc_en_q, s1_acc_en_d;
  logic       s1_load_q,   s1_load_d;
  vec_t       s1_init_q,   s1_init_d;
  vec_t       s1_p_q,      s1_p_d;

  // Stage 2 registers
  vec_t             acc_q, acc_d;
  vec_t             out_q, out_d;
  logic [LANES-1:0] ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // Handshake
  logic s2_free, s2_take, accept;

  assign s2_free      = !out_valid_q || bus.out_ready;
  assign s2_take      = s1_valid_q && s2_free;
  assign bus.in_ready = !s1_valid_q || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 combine
  // ---------------------------------------------------------------------------
  logic [2:0] in_mode;
  int         in_grp;
  vec_t       grp_sum [LANES];
  vec_t       comb_p;

  always_comb begin
    // NOTE: every variable gets a value before any conditional logic, so no
    // path leaves one unassigned and no latch is inferred.
    in_mode = (bus.mode > 3'(LOG2_LANES)) ? 3'(LOG2_LANES) : bus.mode;
    in_grp  = 1 << in_mode;
    comb_p  = '0;
    for (int k = 0; k < LANES; k++) begin
      grp_sum[k] = '0;
      // Only group bases accumulate; lane j contributes at offset (j-k) lanes.
      for (int j = 0; j < LANES; j++) begin
        if ((k % in_grp) == 0 && j >= k && j < k + in_grp) begin
          grp_sum[k] = grp_sum[k]
                     + (vec_t'(bus.partials[j*INT_WIDTH +: INT_WIDTH]) << ((j - k) * MIN_WIDTH));
        end
      end
      if ((k % in_grp) == 0) begin
        comb_p = comb_p | ((grp_sum[k] & group_mask(in_grp)) << (k * ACC_WIDTH));
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_acc_en_d = s1_acc_en_q;
    s1_load_d   = s1_load_q;
    s1_init_d   = s1_init_q;
    s1_p_d      = s1_p_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_mode_d   = in_mode;
      s1_acc_en_d = bus.acc_en;
      s1_load_d   = bus.load;
      s1_init_d   = bus.init_val;
      s1_p_d      = comb_p;
    end else if (s2_take) begin
      s1_valid_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 accumulate / pass
  // ---------------------------------------------------------------------------
  int               s2_grp;
  vec_t             base_sel;
  vec_t             new_acc;
  wide_t            sum_w;
  logic             carry;
  logic [LANES-1:0] grp_carry;   // carry of each group, kept on its top lane

  always_comb begin
    s2_grp    = 1 << s1_mode_q;
    base_sel  = s1_load_q ? s1_init_q : acc_q;
    new_acc   = '0;
    sum_w     = '0;
    carry     = 1'b0;
    grp_carry = '0;
    for (int k = 0; k < LANES; k++) begin
      if ((k % s2_grp) == 0) begin
        sum_w = wide_t'((base_sel >> (k * ACC_WIDTH)) & group_mask(s2_grp))
              + wide_t'((s1_p_q   >> (k * ACC_WIDTH)) & group_mask(s2_grp));
        carry   = |(sum_w >> (s2_grp * ACC_WIDTH));
        new_acc = new_acc | ((vec_t'(sum_w) & group_mask(s2_grp)) << (k * ACC_WIDTH));
        for (int i = 0; i < LANES; i++) begin
          if (i == k + s2_grp - 1) grp_carry[i] = carry;
        end
      end
    end

    acc_d       = acc_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (s2_take) begin
      out_valid_d = 1'b1;
      if (s1_acc_en_q) begin
        acc_d = new_acc;
        out_d = new_acc;
        for (int i = 0; i < LANES; i++) begin
          if ((i % s2_grp) == s2_grp - 1) begin
            ovf_d[i] = (s1_load_q ? 1'b0 : ovf_q[i]) | grp_carry[i];
          end else begin
            ovf_d[i] = 1'b0;
          end
        end
      end else begin
        // Multiply-only beat: accumulator and flags untouched, load ignored.
        out_d = s1_p_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      s1_acc_en_q <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_init_q   <= '0;
      s1_p_q      <= '0;
      // NOTE: the accumulator slices are architectural state that a non-load
      // beat reads back, so they are cleared by reset like any control flop.
      acc_q       <= '0;
      out_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_acc_en_q <= s1_acc_en_d;
      s1_load_q   <= s1_load_d;
      s1_init_q   <= s1_init_d;
      s1_p_q      <= s1_p_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule
